// File: rtl/pcie_pkg.sv
// Shared definitions for the PCIe Gen1 soft-endpoint TX path.
// Holds the 8b/10b symbol constants, the LTSSM ordered-set select
// encoding and the TX framer state encoding.
package pcie_pkg;

  localparam logic [7:0] COM       = 8'hBC;  // K28.5
  localparam logic [7:0] SKP       = 8'h1C;  // K28.0
  localparam logic [7:0] IDL       = 8'h7C;  // K28.3
  localparam logic [7:0] PAD       = 8'hF7;  // K23.7
  localparam logic [7:0] TS1_ID    = 8'h4A;  // D10.2
  localparam logic [7:0] TS2_ID    = 8'h45;  // D5.2
  localparam logic [7:0] RATE_GEN1 = 8'h02;

  typedef enum logic [1:0] {
    OS_DATA = 2'd0,
    OS_TS1  = 2'd1,
    OS_TS2  = 2'd2,
    OS_EIOS = 2'd3
  } os_type_e;

  typedef enum logic [2:0] {
    ST_RST,
    ST_DATA,
    ST_TS,
    ST_SKP,
    ST_EIOS
  } state_e;

endpackage

// File: rtl/pcie_gen1_tx_framer_skp.sv
// SKP ordered-set scheduler.
// Ports:
//   txusrclk2, pcie_rst_n : clock / async active-low reset
//   run                   : count this cycle (low while the framer is in RST)
//   clear                 : restart the interval and drop the pending request
//   skp_pending           : a SKP ordered set is owed at the next boundary
module pcie_skp_scheduler #(
  parameter int unsigned SKP_INTERVAL = 600
) (
  input  logic txusrclk2,
  input  logic pcie_rst_n,
  input  logic run,
  input  logic clear,
  output logic skp_pending
);

  localparam logic [10:0] CNT_LAST = 11'(SKP_INTERVAL - 1);

  logic [10:0] cnt_q;

  // A second expiry while still pending just re-arms; requests never queue.
  always_ff @(posedge txusrclk2 or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      cnt_q       <= '0;
      skp_pending <= 1'b0;
    end else if (clear) begin
      cnt_q       <= '0;
      skp_pending <= 1'b0;
    end else if (run) begin
      if (cnt_q == CNT_LAST) begin
        cnt_q       <= '0;
        skp_pending <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 11'd1;
      end
    end
  end

endmodule

// File: rtl/pcie_gen1_tx_framer.sv
// Single-lane PCIe Gen1 transmit framer driving the GTP 16-bit TX interface.
// Generates TS1/TS2/EIOS for the LTSSM, passes DLL beats in link-active mode
// and inserts SKP ordered sets between packets.
// Ports:
//   txusrclk2, pcie_rst_n        : clock / async active-low reset
//   os_type                      : 0 DATA, 1 TS1, 2 TS2, 3 EIOS
//   link_num/link_pad, lane_num/lane_pad, n_fts, training_ctl : TS fields
//   dll_data/dll_charisk/dll_valid/dll_last, dll_ready : DLL beat handshake
//   tx_data/tx_charisk           : to GTP, [7:0] sent first
//   os_done                      : pulse with the last word of TS1/TS2/EIOS
//   underrun                     : sticky, DLL starved mid-packet
module pcie_gen1_tx_framer
  import pcie_pkg::*;
#(
  parameter int unsigned SKP_INTERVAL = 600
) (
  input  logic        txusrclk2,
  input  logic        pcie_rst_n,
  input  logic [1:0]  os_type,
  input  logic [7:0]  link_num,
  input  logic        link_pad,
  input  logic [7:0]  lane_num,
  input  logic        lane_pad,
  input  logic [7:0]  n_fts,
  input  logic [4:0]  training_ctl,
  input  logic [15:0] dll_data,
  input  logic [1:0]  dll_charisk,
  input  logic        dll_valid,
  input  logic        dll_last,
  output logic        dll_ready,
  output logic [15:0] tx_data,
  output logic [1:0]  tx_charisk,
  output logic        os_done,
  output logic        underrun
);

  state_e      state_q, state_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic        ts2_q, ts2_d;
  logic        boundary;
  logic        in_packet_q;
  logic        skp_pending;
  logic        skp_clear;
  logic        accept;
  os_type_e    os_sel;

  logic [7:0]  lane_q;
  logic        lane_pad_q;
  logic [7:0]  nfts_q;
  logic [4:0]  tctl_q;

  logic [15:0] word_d;
  logic [1:0]  k_d;
  logic        done_d;

  assign os_sel = os_type_e'(os_type);

  assign dll_ready = (state_q == ST_DATA)
                   && !(skp_pending && !in_packet_q)
                   && !((os_type != 2'd0) && !in_packet_q);
  assign accept    = dll_ready && dll_valid;

  // Interval restarts on the first SKP word so the period is
  // SKP_INTERVAL + 2 cycles while the link idles.
  assign skp_clear = (state_q == ST_SKP) && (wcnt_q == 3'd0);

  pcie_skp_scheduler #(
    .SKP_INTERVAL (SKP_INTERVAL)
  ) u_skp (
    .txusrclk2   (txusrclk2),
    .pcie_rst_n  (pcie_rst_n),
    .run         (state_q != ST_RST),
    .clear       (skp_clear),
    .skp_pending (skp_pending)
  );

  always_ff @(posedge txusrclk2 or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      state_q <= ST_RST;
      wcnt_q  <= '0;
      ts2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ts2_q   <= ts2_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    ts2_d    = ts2_q;
    boundary = 1'b0;
    case (state_q)
      ST_RST:          boundary = 1'b1;
      ST_DATA:         boundary = !in_packet_q;
      ST_TS:           boundary = (wcnt_q == 3'd7);
      ST_SKP, ST_EIOS: boundary = (wcnt_q == 3'd1);
      default:         boundary = 1'b1;
    endcase
    if (boundary) begin
      wcnt_d = '0;
      if (skp_pending) begin
        state_d = ST_SKP;
      end else begin
        case (os_sel)
          OS_TS1, OS_TS2: begin
            state_d = ST_TS;
            ts2_d   = (os_sel == OS_TS2);
          end
          OS_EIOS: state_d = ST_EIOS;
          default: state_d = ST_DATA;
        endcase
      end
    end else if (state_q != ST_DATA) begin
      wcnt_d = wcnt_q + 3'd1;
    end
  end

  // Word selection; registered below so every FSM word lands one cycle later.
  always_comb begin
    word_d = '0;
    k_d    = '0;
    done_d = 1'b0;
    case (state_q)
      ST_DATA: begin
        if (accept) begin
          word_d = dll_data;
          k_d    = dll_charisk;
        end
      end
      ST_TS: begin
        case (wcnt_q)
          3'd0: begin
            word_d = {(link_pad ? PAD : link_num), COM};
            k_d    = {link_pad, 1'b1};
          end
          3'd1: begin
            word_d = {nfts_q, (lane_pad_q ? PAD : lane_q)};
            k_d    = {1'b0, lane_pad_q};
          end
          3'd2: word_d = {3'b000, tctl_q, RATE_GEN1};
          default: begin
            word_d = ts2_q ? {TS2_ID, TS2_ID} : {TS1_ID, TS1_ID};
            done_d = (wcnt_q == 3'd7);
          end
        endcase
      end
      ST_SKP: begin
        if (wcnt_q == 3'd0) begin
          word_d = {SKP, COM};
          k_d    = 2'b01;
        end else begin
          word_d = {SKP, SKP};
          k_d    = 2'b11;
        end
      end
      ST_EIOS: begin
        if (wcnt_q == 3'd0) begin
          word_d = {IDL, COM};
          k_d    = 2'b01;
        end else begin
          word_d = {IDL, IDL};
          k_d    = 2'b11;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge txusrclk2 or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      tx_data     <= '0;
      tx_charisk  <= '0;
      os_done     <= 1'b0;
      underrun    <= 1'b0;
      in_packet_q <= 1'b0;
      lane_q      <= '0;
      lane_pad_q  <= 1'b0;
      nfts_q      <= '0;
      tctl_q      <= '0;
    end else begin
      tx_data    <= word_d;
      tx_charisk <= k_d;
      os_done    <= done_d;
      if (accept) in_packet_q <= !dll_last;
      if ((state_q == ST_DATA) && in_packet_q && !dll_valid) underrun <= 1'b1;
      // TS fields are captured with w0 and held for w1/w2 of the same set.
      if ((state_q == ST_TS) && (wcnt_q == 3'd0)) begin
        lane_q     <= lane_num;
        lane_pad_q <= lane_pad;
        nfts_q     <= n_fts;
        tctl_q     <= training_ctl;
      end
    end
  end

endmodule

// File: tb/tb_pcie_gen1_tx_framer.sv
// Self-checking bench for pcie_gen1_tx_framer: directed table and sequences
// plus randomized traffic against a queue-based reference model.
module tb_pcie_gen1_tx_framer;

  localparam int unsigned INTV = 600;

  logic        txusrclk2 = 1'b0;
  logic        pcie_rst_n = 1'b1;
  logic [1:0]  os_type = 2'd0;
  logic [7:0]  link_num = '0;
  logic        link_pad = 1'b0;
  logic [7:0]  lane_num = '0;
  logic        lane_pad = 1'b0;
  logic [7:0]  n_fts = '0;
  logic [4:0]  training_ctl = '0;
  logic [15:0] dll_data = '0;
  logic [1:0]  dll_charisk = '0;
  logic        dll_valid = 1'b0;
  logic        dll_last = 1'b0;
  logic        dll_ready;
  logic [15:0] tx_data;
  logic [1:0]  tx_charisk;
  logic        os_done;
  logic        underrun;

  always #4 txusrclk2 = ~txusrclk2;

  pcie_gen1_tx_framer #(
    .SKP_INTERVAL (INTV)
  ) u_dut (
    .txusrclk2    (txusrclk2),
    .pcie_rst_n   (pcie_rst_n),
    .os_type      (os_type),
    .link_num     (link_num),
    .link_pad     (link_pad),
    .lane_num     (lane_num),
    .lane_pad     (lane_pad),
    .n_fts        (n_fts),
    .training_ctl (training_ctl),
    .dll_data     (dll_data),
    .dll_charisk  (dll_charisk),
    .dll_valid    (dll_valid),
    .dll_last     (dll_last),
    .dll_ready    (dll_ready),
    .tx_data      (tx_data),
    .tx_charisk   (tx_charisk),
    .os_done      (os_done),
    .underrun     (underrun)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words owed by the current ordered set; an
  // empty queue means the link is in data mode.
  typedef struct {
    logic [15:0] d;
    logic [1:0]  k;
    bit          done;
    bit          skp0;
    int          tag;   // 1..3: TS w0..w2, built from fields when sent
  } mw_t;

  mw_t         mq[$];
  bit          m_rst, m_inpkt, m_pend, m_under;
  int unsigned m_cnt;
  logic [7:0]  m_lane, m_nfts;
  bit          m_lane_pad;
  logic [4:0]  m_tctl;
  logic [15:0] e_d;
  logic [1:0]  e_k;
  bit          e_done;

  function automatic mw_t mk(logic [15:0] d, logic [1:0] k, bit done, bit skp0, int tag);
    mw_t w;
    w.d = d; w.k = k; w.done = done; w.skp0 = skp0; w.tag = tag;
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rst = 1; m_inpkt = 0; m_pend = 0; m_under = 0; m_cnt = 0;
    e_d = '0; e_k = '0; e_done = 0;
  endtask

  task automatic model_choose(input bit pend);
    logic [7:0] id;
    if (pend) begin
      mq.push_back(mk(16'h1CBC, 2'b01, 0, 1, 0));
      mq.push_back(mk(16'h1C1C, 2'b11, 0, 0, 0));
    end else if (os_type == 2'd1 || os_type == 2'd2) begin
      id = (os_type == 2'd2) ? 8'h45 : 8'h4A;
      for (int t = 1; t <= 3; t++) mq.push_back(mk('0, '0, 0, 0, t));
      for (int i = 0; i < 5; i++) mq.push_back(mk({id, id}, 2'b00, (i == 4), 0, 0));
    end else if (os_type == 2'd3) begin
      mq.push_back(mk(16'h7CBC, 2'b01, 0, 0, 0));
      mq.push_back(mk(16'h7C7C, 2'b11, 1, 0, 0));
    end
  endtask

  task automatic model_step(output bit er);
    bit  bnd, clr, pend0;
    mw_t w;
    e_d = '0; e_k = '0; e_done = 0; er = 0; bnd = 0; clr = 0; pend0 = m_pend;
    if (m_rst) begin
      m_rst = 0;
      bnd = 1;
    end else begin
      if (mq.size() > 0) begin
        w = mq.pop_front();
        case (w.tag)
          1: begin
            m_lane = lane_num; m_lane_pad = lane_pad; m_nfts = n_fts; m_tctl = training_ctl;
            e_d = {(link_pad ? 8'hF7 : link_num), 8'hBC};
            e_k = {link_pad, 1'b1};
          end
          2: begin
            e_d = {m_nfts, (m_lane_pad ? 8'hF7 : m_lane)};
            e_k = {1'b0, m_lane_pad};
          end
          3: e_d = {3'b000, m_tctl, 8'h02};
          default: begin e_d = w.d; e_k = w.k; end
        endcase
        e_done = w.done;
        clr = w.skp0;
        bnd = (mq.size() == 0);
      end else begin
        er  = m_inpkt || (!m_pend && os_type == 2'd0);
        bnd = !m_inpkt;
        if (er && dll_valid) begin
          e_d = dll_data; e_k = dll_charisk;
          m_inpkt = !dll_last;
        end else if (m_inpkt && !dll_valid) begin
          m_under = 1;
        end
      end
      if (clr) begin m_cnt = 0; m_pend = 0; end
      else if (m_cnt == INTV - 1) begin m_cnt = 0; m_pend = 1; end
      else m_cnt++;
    end
    if (bnd) model_choose(pend0);
  endtask

  // One clock: starts and ends just after a falling edge, inputs already set.
  task automatic tick();
    bit er;
    #1;
    model_step(er);
    chk("dll_ready", dll_ready, er);
    @(posedge txusrclk2);
    @(negedge txusrclk2);
    chk("tx_data", tx_data, e_d);
    chk("tx_charisk", tx_charisk, e_k);
    chk("os_done", os_done, e_done);
    chk("underrun", underrun, m_under);
  endtask

  task automatic do_reset();
    pcie_rst_n = 1'b0;
    #1;
    chk("rst_tx_data", tx_data, 16'h0000);
    chk("rst_tx_charisk", tx_charisk, 2'b00);
    chk("rst_os_done", os_done, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_dll_ready", dll_ready, 1'b0);
    @(negedge txusrclk2);
    pcie_rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [1:0]  os;
    logic [15:0] d;
    logic [1:0]  k;
    bit          done;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          hits, nskp, last_skp;
    bit          prev;

    tbl[0] = '{2'd1, 16'h0000, 2'b00, 0};
    tbl[1] = '{2'd1, 16'h00BC, 2'b01, 0};
    tbl[2] = '{2'd1, 16'h1000, 2'b00, 0};
    tbl[3] = '{2'd1, 16'h0002, 2'b00, 0};
    for (int i = 4; i < 8; i++) tbl[i] = '{2'd1, 16'h4A4A, 2'b00, 0};
    tbl[8] = '{2'd1, 16'h4A4A, 2'b00, 1};
    tbl[9] = '{2'd1, 16'h00BC, 2'b01, 0};

    // TS1 straight out of reset
    os_type = 2'd1; link_num = 8'h00; lane_num = 8'h00; n_fts = 8'h10; training_ctl = 5'h00;
    #2;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      os_type = tbl[i].os;
      tick();
      chk("tbl_tx_data", tx_data, tbl[i].d);
      chk("tbl_tx_charisk", tx_charisk, tbl[i].k);
      chk("tbl_os_done", os_done, tbl[i].done);
    end

    // TS2 with PAD link and lane
    os_type = 2'd2; link_pad = 1'b1; lane_pad = 1'b1; n_fts = 8'h33; training_ctl = 5'h15;
    hits = 0; prev = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (prev) begin
        chk("ts2_w1_data", tx_data, 16'h33F7);
        chk("ts2_w1_k", tx_charisk, 2'b01);
        hits++;
      end
      prev = (tx_data == 16'hF7BC) && (tx_charisk == 2'b11);
    end
    chk("ts2_seen", (hits > 0), 1'b1);

    // switch to EIOS in the middle of a TS1, then reset mid-EIOS
    os_type = 2'd1; link_pad = 1'b0; lane_pad = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    os_type = 2'd3;
    hits = 0; prev = 0;
    for (int i = 0; i < 30 && hits == 0; i++) begin
      tick();
      if (prev) begin
        chk("eios_w1_data", tx_data, 16'h7C7C);
        chk("eios_w1_k", tx_charisk, 2'b11);
        chk("eios_w1_done", os_done, 1'b1);
        hits++;
      end
      prev = (tx_data == 16'h7CBC) && (tx_charisk == 2'b01);
    end
    chk("eios_seen", (hits > 0), 1'b1);
    hits = 0;
    for (int i = 0; i < 10 && hits == 0; i++) begin
      tick();
      if (tx_data == 16'h7CBC) hits++;
    end
    chk("eios_again", (hits > 0), 1'b1);
    os_type = 2'd0;
    do_reset();

    // underrun at beat 4
    tick();
    for (int i = 0; i < 3; i++) begin
      dll_valid = 1'b1; dll_data = 16'h5100 + 16'(i); dll_charisk = 2'b00; dll_last = 1'b0;
      tick();
      chk("pkt_beat", tx_data, 16'h5100 + 16'(i));
    end
    dll_valid = 1'b0;
    tick();
    chk("underrun_set", underrun, 1'b1);
    chk("underrun_idle", tx_data, 16'h0000);
    for (int i = 0; i < 20; i++) tick();
    chk("underrun_sticky", underrun, 1'b1);
    do_reset();

    // idle link: SKP every INTV+2 cycles
    nskp = 0; last_skp = -1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (tx_data == 16'h1CBC) begin
        chk("skp_k", tx_charisk, 2'b01);
        if (last_skp >= 0) chk("skp_period", i - last_skp, 602);
        else chk("skp_first", i, 602);
        last_skp = i;
        nskp++;
      end else begin
        chk("idle_word", (tx_data == 16'h0000) || (tx_data == 16'h1C1C), 1'b1);
      end
    end
    chk("skp_count", nskp, 3);

    // 10-beat packet accepted two cycles before SKP expiry
    hits = 0;
    for (int i = 0; i < 700 && m_cnt != INTV - 3; i++) tick();
    chk("pkt_align", m_cnt, INTV - 3);
    for (int i = 0; i < 10; i++) begin
      dll_valid = 1'b1; dll_data = 16'hA000 + 16'(i); dll_charisk = 2'(i);
      dll_last = (i == 9);
      tick();
      chk("pkt10_beat", tx_data, 16'hA000 + 16'(i));
    end
    dll_valid = 1'b0; dll_last = 1'b0;
    tick();
    chk("pkt10_gap", tx_data, 16'h0000);
    tick();
    chk("pkt10_skp0", tx_data, 16'h1CBC);
    tick();
    chk("pkt10_skp1", tx_data, 16'h1C1C);

    // randomized traffic with live TS field changes
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      if (i % 250 == 0) begin
        case ($urandom_range(0, 5))
          1: os_type = 2'd1;
          2: os_type = 2'd2;
          3: os_type = 2'd3;
          default: os_type = 2'd0;
        endcase
      end
      link_num = 8'($urandom); lane_num = 8'($urandom); n_fts = 8'($urandom);
      training_ctl = 5'($urandom); link_pad = ($urandom_range(0, 3) == 0);
      lane_pad = ($urandom_range(0, 3) == 0);
      dll_valid = ($urandom_range(0, 99) != 0);
      dll_data = 16'($urandom); dll_charisk = 2'($urandom);
      dll_last = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
